// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM states
//   MAGIC_DEFAULT  : default frame start byte
//   LEN_W          : width of the frame word-count field
//   ADDR_W         : width of the byte address presented to instruction memory
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned ADDR_W        = 12;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
//   rx_byte/rx_valid            : bytes from the UART receiver (one-cycle strobe)
//   mem_we/mem_addr/mem_wdata   : one-cycle word write to instruction memory
// master : the loader (consumes bytes, drives the write port)
// slave  : the surrounding system (UART side and memory side)
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    input  rx_byte, rx_valid,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_byte, rx_valid,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/loader_timeout.sv
// Inter-byte idle counter for the boot loader.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : zero the counter (takes priority over en)
//   en           : count one idle cycle
//   expired      : counter has reached TIMEOUT (holds until cleared)
module loader_timeout #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt >= CW'(TIMEOUT));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed image over a byte stream and writes it into
// instruction memory while holding the core in reset.
// Frame: MAGIC, LEN_LO, LEN_HI, LEN*4 payload bytes (little-endian words), CSUM
// where CSUM is the XOR of all payload bytes.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse arming the loader (honoured in IDLE/DONE/ERR)
//   bus          : byte input and instruction-memory write port
//   cpu_hold     : high while the core must stay in reset
//   done         : frame loaded with a good checksum (sticky until next start)
//   error        : frame rejected (sticky until next start)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter logic [7:0]  MAGIC   = MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  imem_loader_if.master  bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           error
);

  state_t           state, state_n;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] word_cnt;
  logic [1:0]       byte_idx;
  logic [31:0]      word_buf;
  logic [31:0]      word_asm;
  logic [7:0]       csum;
  logic             timed;
  logic             expired;
  logic             accept;
  logic             start_ok;
  logic             last_word;

  assign timed     = (state inside {LEN_LO, LEN_HI, DATA, CHECK});
  assign start_ok  = start && (state inside {IDLE, DONE, ERR});
  // A byte arriving on the same cycle the timeout fires is dropped so that the
  // datapath never acts on a frame the FSM is already rejecting.
  assign accept    = bus.rx_valid && !expired;
  assign len_full  = {bus.rx_byte, len[7:0]};
  assign last_word = ((word_cnt + LEN_W'(1)) == len);

  always_comb begin
    word_asm = word_buf;
    word_asm[8*byte_idx +: 8] = bus.rx_byte;
  end

  // Counter is held at zero outside the timed states, which also covers the
  // clear on entry to SYNC.
  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.rx_valid || !timed),
    .en      (timed),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) state_n = SYNC;
      SYNC:   if (bus.rx_valid && bus.rx_byte == MAGIC) state_n = LEN_LO;
      LEN_LO: begin
        if (expired)     state_n = ERR;
        else if (accept) state_n = LEN_HI;
      end
      LEN_HI: begin
        if (expired) state_n = ERR;
        else if (accept) begin
          if (len_full > LEN_W'(DEPTH)) state_n = ERR;
          else if (len_full == '0)      state_n = CHECK;
          else                          state_n = DATA;
        end
      end
      DATA: begin
        if (expired) state_n = ERR;
        else if (accept && byte_idx == 2'd3 && last_word) state_n = CHECK;
      end
      CHECK: begin
        if (expired)     state_n = ERR;
        else if (accept) state_n = (bus.rx_byte == csum) ? DONE : ERR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len           <= '0;
      word_cnt      <= '0;
      byte_idx      <= '0;
      word_buf      <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start_ok) begin
        len      <= '0;
        word_cnt <= '0;
        byte_idx <= '0;
        word_buf <= '0;
        csum     <= '0;
      end
      if (accept) begin
        unique case (state)
          LEN_LO: len[7:0]  <= bus.rx_byte;
          LEN_HI: len[15:8] <= bus.rx_byte;
          DATA: begin
            word_buf <= word_asm;
            csum     <= csum ^ bus.rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= word_asm;
              bus.mem_addr  <= {word_cnt[ADDR_W-3:0], 2'b00};
              word_cnt      <= word_cnt + LEN_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned TMO = 40;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(
    .DEPTH   (128),
    .MAGIC   (8'hA5),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [11:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  seq[$];

  // Write log, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n && bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_seq();
    foreach (seq[k]) send_byte(seq[k]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] cs;
    bit         seen;

    reset_n      = 1'b0;
    start        = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_done",  32'(done),          32'd0);
    check("rst_error", 32'(error),         32'd0);
    check("rst_hold",  32'(cpu_hold),      32'd1);
    check("rst_we",    32'(bus.mem_we),    32'd0);
    check("rst_addr",  32'(bus.mem_addr),  32'd0);
    check("rst_wdata", bus.mem_wdata,      32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Normal two-word load; checksum 13^6F^F0^9F^FF = EC.
    pulse_start();
    check("arm_hold", 32'(cpu_hold), 32'd1);
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'hF0, 8'h9F, 8'hFF, 8'hEC};
    send_seq();
    check("norm_nwr",   32'(wa.size()), 32'd2);
    check("norm_a0",    32'(wa[0]),     32'h000);
    check("norm_d0",    wd[0],          32'h0000_0013);
    check("norm_a1",    32'(wa[1]),     32'h004);
    check("norm_d1",    wd[1],          32'hFF9F_F06F);
    check("norm_done",  32'(done),      32'd1);
    check("norm_err",   32'(error),     32'd0);
    check("norm_hold",  32'(cpu_hold),  32'd0);
    send_byte(8'hA5);
    check("done_ignore_rx", 32'(done),  32'd1);

    // Bad checksum: writes still happen, frame rejected.
    pulse_start();
    check("restart_done_clr", 32'(done),     32'd0);
    check("restart_hold",     32'(cpu_hold), 32'd1);
    seq[11] = 8'h00;
    send_seq();
    check("bad_nwr",  32'(wa.size()), 32'd2);
    check("bad_err",  32'(error),     32'd1);
    check("bad_done", 32'(done),      32'd0);
    check("bad_hold", 32'(cpu_hold),  32'd1);

    // Oversize length 129.
    pulse_start();
    check("restart_err_clr", 32'(error), 32'd0);
    seq = '{8'hA5, 8'h81, 8'h00};
    send_seq();
    check("big_err", 32'(error),     32'd1);
    check("big_nwr", 32'(wa.size()), 32'd0);

    // Length exactly DEPTH, bytes 0..511 (mod 256).
    pulse_start();
    seq = '{8'hA5, 8'h80, 8'h00};
    send_seq();
    check("full_len_ok", 32'(error), 32'd0);
    cs = 8'h00;
    for (int k = 0; k < 512; k++) begin
      send_byte(8'(k));
      cs ^= 8'(k);
    end
    send_byte(cs);
    check("full_nwr",   32'(wa.size()), 32'd128);
    check("full_alast", 32'(wa[127]),   32'h1FC);
    check("full_dlast", wd[127],        32'hFFFE_FDFC);
    check("full_d1",    wd[1],          32'h0706_0504);
    check("full_done",  32'(done),      32'd1);

    // Sync noise followed by an empty frame.
    pulse_start();
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    send_seq();
    check("empty_nwr",  32'(wa.size()), 32'd0);
    check("empty_done", 32'(done),      32'd1);
    check("empty_hold", 32'(cpu_hold),  32'd0);

    // Timeout mid-word.
    pulse_start();
    seq = '{8'hA5, 8'h01, 8'h00, 8'h13};
    send_seq();
    repeat (30) @(negedge clk);
    check("tmo_early", 32'(error), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = error;
    end
    check("tmo_err", 32'(error),     32'd1);
    check("tmo_nwr", 32'(wa.size()), 32'd0);

    // Reset mid-frame, then a fresh load.
    pulse_start();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_seq();
    reset_n = 1'b0;
    #1;
    check("mrst_done",  32'(done),         32'd0);
    check("mrst_error", 32'(error),        32'd0);
    check("mrst_hold",  32'(cpu_hold),     32'd1);
    check("mrst_we",    32'(bus.mem_we),   32'd0);
    check("mrst_addr",  32'(bus.mem_addr), 32'd0);
    check("mrst_wdata", bus.mem_wdata,     32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
            8'h6F, 8'hF0, 8'h9F, 8'hFF, 8'hEC};
    send_seq();
    check("rl_nwr",  32'(wa.size()), 32'd2);
    check("rl_a0",   32'(wa[0]),     32'h000);
    check("rl_d0",   wd[0],          32'h0000_0013);
    check("rl_a1",   32'(wa[1]),     32'h004);
    check("rl_done", 32'(done),      32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
